// File: rtl/toggle_pulse_gen_if.sv
// Control/status bundle between a sequencer and the toggle pulse generator.
interface toggle_pulse_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] burst;
    logic             t;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, stop, div, burst,
        input  t, busy, done, remaining
    );

    modport slave (
        input  start, stop, div, burst,
        output t, busy, done, remaining
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Toggle-enable pulse generator feeding a T flip-flop stage.
// Emits single-cycle t pulses every div+1 cycles, either a counted burst
// (burst != 0) or continuously (burst == 0) until stop.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; all outputs low
//   S_RUN  | phase counter running, t pulses on phase terminal count
//   S_DONE | counted burst finished; one cycle of done, then back to idle
module toggle_pulse_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    toggle_pulse_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic             t_q,     t_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // State and registered outputs; reset clears everything so nothing fires on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            div_q   <= '0;
            burst_q <= '0;
            rem_q   <= '0;
            t_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            burst_q <= burst_d;
            rem_q   <= rem_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output decode; t and done are pulses, so they default low.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        div_d   = div_q;
        burst_d = burst_q;
        rem_d   = rem_q;
        t_d     = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                rem_d  = '0;
                // stop has priority over a simultaneous start
                if (bus.start && !bus.stop) begin
                    div_d   = bus.div;
                    burst_d = bus.burst;
                    phase_d = bus.div;
                    busy_d  = 1'b1;
                    rem_d   = bus.burst;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    busy_d  = 1'b0;
                    rem_d   = '0;
                    state_d = S_IDLE;
                end else if (phase_q == '0) begin
                    t_d     = 1'b1;
                    phase_d = div_q;
                    if (burst_q != '0) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end

            S_DONE: begin
                // stop is ignored here; the completion pulse always goes out
                busy_d  = 1'b0;
                done_d  = 1'b1;
                rem_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                rem_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.t         = t_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen: directed scenarios plus a random
// stretch, compared every cycle against a pulse-schedule reference model.
module tb_toggle_pulse_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;

    toggle_pulse_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    toggle_pulse_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cycle    = 0;
    string cur_tag  = "reset";

    // reference model: pulses fall on edges e0 + k*(D+1), k = 1..B
    bit          m_active;
    bit          m_done_pend;
    int          m_e0;
    int          m_D;
    int          m_B;
    int          m_n;
    logic        e_t;
    logic        e_busy;
    logic        e_done;
    logic [7:0]  e_rem;
    int          pulse_cnt;
    logic        tff_q;

    task automatic model_clear();
        m_active    = 1'b0;
        m_done_pend = 1'b0;
        m_n         = 0;
        e_t         = 1'b0;
        e_busy      = 1'b0;
        e_done      = 1'b0;
        e_rem       = '0;
    endtask

    task automatic model_edge();
        if (m_done_pend) begin
            m_done_pend = 1'b0;
            e_t = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_rem = '0;
        end else if (!m_active) begin
            e_t = 1'b0; e_done = 1'b0;
            if (bus.start && !bus.stop) begin
                m_active = 1'b1;
                m_e0     = cycle;
                m_D      = int'(bus.div);
                m_B      = int'(bus.burst);
                m_n      = 0;
                e_busy   = 1'b1;
                e_rem    = bus.burst;
            end else begin
                e_busy = 1'b0;
                e_rem  = '0;
            end
        end else begin
            e_done = 1'b0;
            if (bus.stop) begin
                m_active = 1'b0;
                e_t = 1'b0; e_busy = 1'b0; e_rem = '0;
            end else if (((cycle - m_e0) % (m_D + 1)) == 0) begin
                e_t    = 1'b1;
                e_busy = 1'b1;
                m_n++;
                if (m_B != 0) begin
                    e_rem = 8'(m_B - m_n);
                    if (m_n == m_B) begin
                        m_active    = 1'b0;
                        m_done_pend = 1'b1;
                    end
                end else begin
                    e_rem = '0;
                end
            end else begin
                e_t    = 1'b0;
                e_busy = 1'b1;
            end
        end
    endtask

    task automatic chk(string tag, logic [10:0] obs, logic [10:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed {t,busy,done,rem}=%h required %h",
                   tag, cycle, obs, exp);
        end
    endtask

    // one clock: model advances on the edge, outputs compared 1 time unit later
    task automatic cyc();
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        chk(cur_tag, {bus.t, bus.busy, bus.done, bus.remaining},
                     {e_t, e_busy, e_done, e_rem});
        if (bus.t === 1'b1) begin
            pulse_cnt++;
            tff_q = ~tff_q;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drive(logic s, logic p, logic [7:0] d, logic [7:0] b);
        bus.start = s;
        bus.stop  = p;
        bus.div   = d;
        bus.burst = b;
    endtask

    initial begin
        int   guard;
        logic tff_start;

        pulse_cnt = 0;
        tff_q     = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        model_clear();
        reset = 1'b0;
        #23;
        chk("reset_state", {bus.t, bus.busy, bus.done, bus.remaining}, 11'd0);
        @(negedge clk);
        reset = 1'b1;
        run(2);

        // counted burst div=3 burst=4; TFF must end at its start value
        cur_tag   = "burst_d3_b4";
        tff_start = tff_q;
        pulse_cnt = 0;
        drive(1'b1, 1'b0, 8'd3, 8'd4);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(20);
        chk("burst_d3_b4_pulses", 11'(pulse_cnt), 11'd4);
        chk("burst_d3_b4_tff", {10'd0, tff_q}, {10'd0, tff_start});

        // div=0: back-to-back pulses
        cur_tag   = "burst_d0_b3";
        pulse_cnt = 0;
        drive(1'b1, 1'b0, 8'd0, 8'd3);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(8);
        chk("burst_d0_b3_pulses", 11'(pulse_cnt), 11'd3);

        // continuous mode, abort after the 6th pulse
        cur_tag   = "cont_d1";
        pulse_cnt = 0;
        drive(1'b1, 1'b0, 8'd1, 8'd0);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        guard = 0;
        while (m_n < 6 && guard < 40) begin
            cyc();
            guard++;
        end
        chk("cont_d1_six_pulses", 11'(m_n), 11'd6);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        run(6);
        chk("cont_d1_pulses_total", 11'(pulse_cnt), 11'd6);

        // start and stop together in idle: nothing happens
        cur_tag = "start_stop_idle";
        drive(1'b1, 1'b1, 8'd2, 8'd2);
        run(3);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(4);

        // start re-asserted mid-run with other settings is ignored
        cur_tag = "restart_ignored";
        drive(1'b1, 1'b0, 8'd2, 8'd3);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(3);
        drive(1'b1, 1'b0, 8'd0, 8'd7);
        run(2);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(12);

        // stop during the DONE cycle is ignored
        cur_tag = "stop_in_done";
        drive(1'b1, 1'b0, 8'd1, 8'd2);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(4);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        run(3);

        // maximum period, single pulse
        cur_tag   = "max_div";
        pulse_cnt = 0;
        drive(1'b1, 1'b0, 8'd255, 8'd1);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(262);
        chk("max_div_pulses", 11'(pulse_cnt), 11'd1);

        // asynchronous reset between pulses of a running burst
        cur_tag = "reset_mid_burst";
        drive(1'b1, 1'b0, 8'd2, 8'd5);
        cyc();
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("reset_mid_burst_async", {bus.t, bus.busy, bus.done, bus.remaining}, 11'd0);
        @(negedge clk);
        reset = 1'b1;
        pulse_cnt = 0;
        run(12);
        chk("reset_mid_burst_quiet", 11'(pulse_cnt), 11'd0);

        // random stretch
        cur_tag = "random";
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 24) == 0,
                  8'($urandom % 4), 8'($urandom % 5));
            cyc();
        end
        drive(1'b0, 1'b1, 8'd0, 8'd0);
        run(2);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        run(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
- Upstream driver for the T flip-flop stage: produces the single-cycle `t` (toggle-enable) pulses that the flip-flop consumes.
- Pulses are spaced at a programmable period and emitted either as a counted burst or continuously.
- Start/stop control and busy/done status let a sequencer drive a toggle stage without hand-timing `t`.

Parameters:
- DIV_W, 8, width of the period divider input `div`.
- CNT_W, 8, width of the burst length input `burst` and the `remaining` output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets immediately, independent of clk.
- start  input  1  level-sampled request; accepted only in IDLE.
- stop  input  1  level-sampled abort; takes effect on the edge where it is sampled.
- div  input  DIV_W  pulse period minus 1; captured at start acceptance.
- burst  input  CNT_W  number of pulses; 0 selects continuous mode; captured at start acceptance.
- t  output  1  registered toggle-enable to the T flip-flop; high for exactly one cycle per pulse.
- busy  output  1  high while a burst or continuous run is active.
- done  output  1  one-cycle pulse when a counted burst completes normally.
- remaining  output  CNT_W  pulses still to emit in a counted burst; 0 in continuous mode and when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: t=0, busy=0, done=0, remaining=0.
  - State: FSM goes to IDLE; phase counter and captured div/burst go to 0.
  - Applies at any point mid-run; no pulse or done is emitted on release.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 and stop=0 at edge E0: capture div→D and burst→B, load phase=D, set busy=1, set remaining=B, go to RUN.
  - start=1 and stop=1 together: stop wins; stay in IDLE with no change.
- RUN, evaluated each edge:
  - If stop=1: go to IDLE; t=0, busy=0, remaining=0, done stays 0.
  - Else if phase==0: t=1 for the following cycle, reload phase=D. If counted mode, decrement remaining; when that decrement reaches 0, go to DONE.
  - Else: t=0, phase decrements by 1.
- Timing: first pulse is high in the cycle after edge E0+D+1; later pulses follow every D+1 cycles. With div=0, t is high on consecutive cycles.
- DONE (one cycle): t=0, busy=0, done=1, remaining=0, then go to IDLE. Net effect: done is high in the cycle immediately after the last t pulse.
- Continuous mode (B=0): remaining holds 0; pulses repeat until stop or reset; done never asserts.
- start while busy (RUN or DONE): ignored; div and burst changes during a run have no effect.
- stop sampled in DONE: ignored; done still completes.
- Counters: phase is DIV_W bits, unsigned, no wrap (reloads at 0). Maximum period is 2^DIV_W cycles; maximum burst is 2^CNT_W−1 pulses.
- t never asserts in IDLE or DONE; busy=0 implies t=0 on the next cycle.

Test Plan:
- Reset mid-burst: div=2, burst=5 running, drop reset between pulses → t=0, busy=0, remaining=0 immediately; after release no t pulse until a new start.
- Counted burst: div=3, burst=4, start pulsed at edge 0 → t high after edges 4, 8, 12, 16; remaining reads 3, 2, 1, 0; done high for one cycle after edge 17; TFF q toggles 4 times and ends at its start value.
- div=0, burst=3 → t high for 3 consecutive cycles starting after edge 1; done in the following cycle; busy low afterwards.
- Continuous with abort: div=1, burst=0 → t every 2nd cycle with remaining=0; stop asserted after the 6th pulse → t=0 and busy=0 next cycle, done never asserts.
- Priority and ignore rules:
  - start and stop together in IDLE → no activity.
  - start re-asserted mid-run with different div/burst → period and count unchanged.
- Max div=255, burst=1 → single pulse 256 cycles after start, then done.
